// File: rtl/imem_loader.sv
// Instruction memory loader: turns a length-prefixed little-endian byte stream into
// word writes at consecutive addresses and keeps the core in reset until a load completes.
module imem_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BOOT_HOLD  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  core_rst_n
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  // Capacity is held one bit wider than the length so N == 2^ADDR_WIDTH stays legal.
  localparam logic [32:0]         CAPACITY = 33'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                  state, state_nx;
  logic [31:0]             len;
  logic [1:0]              byte_cnt;
  logic [ADDR_WIDTH:0]     word_cnt;
  logic [DATA_WIDTH-1:0]   word_sr;
  logic                    loaded;

  logic                    xfer;
  logic                    last_byte;
  logic                    last_word;
  logic [31:0]             len_full;
  logic [DATA_WIDTH-1:0]   word_full;
  logic                    busy_nx;
  logic                    idle_like;

  assign xfer      = in_valid & in_ready;
  assign last_byte = (byte_cnt == 2'd3);
  assign len_full  = {in_data, len[23:0]};
  assign word_full = {in_data, word_sr[DATA_WIDTH-1:8]};
  assign last_word = ((word_cnt + CNT_ONE) == len[ADDR_WIDTH:0]);
  assign busy_nx   = (state_nx == LEN) || (state_nx == DATA) || (state_nx == FLUSH);
  assign idle_like = (state == IDLE) || (state == DONE) || (state == ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = LEN;
      end
      LEN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer && last_byte) begin
          if (len_full == 32'd0)                state_nx = DONE;
          else if ({1'b0, len_full} > CAPACITY) state_nx = ERR;
          else                                  state_nx = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer && last_byte && last_word) state_nx = FLUSH;
      end
      FLUSH: begin
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE, ERR: begin
        if (start) state_nx = LEN;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Byte assembly, write strobe and status flags; status follows the next state so it is
  // valid in the same cycle the FSM lands in DONE/ERR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len        <= '0;
      byte_cnt   <= '0;
      word_cnt   <= '0;
      word_sr    <= '0;
      loaded     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      core_rst_n <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (idle_like && start) begin
        byte_cnt <= '0;
      end
      if (xfer) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (state == LEN) begin
          len[8*byte_cnt +: 8] <= in_data;
          if (last_byte) word_cnt <= '0;
        end else begin
          word_sr <= word_full;
          if (last_byte) begin
            mem_we    <= 1'b1;
            mem_addr  <= word_cnt[ADDR_WIDTH-1:0];
            mem_wdata <= word_full;
            word_cnt  <= word_cnt + CNT_ONE;
          end
        end
      end
      done   <= (state_nx == DONE);
      err    <= (state_nx == ERR);
      loaded <= loaded | (state_nx == DONE);
      if (busy_nx)              core_rst_n <= 1'b0;
      else if (BOOT_HOLD == 0)  core_rst_n <= 1'b1;
      else                      core_rst_n <= loaded | (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: frames go through a reference model that derives the
// expected write list and final status directly from the frame format.
module tb_imem_loader;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic          core_rst_n;

  imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .BOOT_HOLD(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .core_rst_n(core_rst_n)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cycleCnt = 0;
  int lastWeCycle = 0;
  int doneCycle = 0;
  logic prevDone = 1'b0;
  logic loadedModel = 1'b0;

  logic [7:0]  frameQ[$];
  logic [31:0] gotAddr[$];
  logic [31:0] gotData[$];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cycleCnt++;

  // Write monitor and done-edge timestamping, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      gotAddr.push_back(32'(mem_addr));
      gotData.push_back(mem_wdata);
      lastWeCycle = cycleCnt;
    end
    if (done && !prevDone) doneCycle = cycleCnt;
    prevDone = done;
  end

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    loadedModel = 1'b0;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_core_rst_n", core_rst_n, 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic buildFrame(input int n, input int words);
    frameQ.delete();
    for (int b = 0; b < 4; b++) frameQ.push_back(8'((n >> (8 * b)) & 8'hFF));
    for (int w = 0; w < words; w++)
      for (int b = 0; b < 4; b++) frameQ.push_back(8'($urandom_range(255, 0)));
  endtask

  // Sends frameQ after a start pulse; midStart >= 0 pulses start again before that byte.
  task automatic applyStimulus(input int maxGap, input int midStart);
    int t;
    gotAddr.delete();
    gotData.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("core_rst_while_busy", core_rst_n, 0);
    foreach (frameQ[k]) begin
      if (k == midStart) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      repeat ($urandom_range(maxGap, 0)) @(negedge clk);
      in_valid = 1'b1;
      in_data  = frameQ[k];
      t = 0;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        checkOutput("byte_accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Reference: frame -> expected writes and final status, then compare.
  task automatic checkSession(input string name);
    int n;
    int expWrites;
    logic expDone, expErr;
    int t;
    n = {frameQ[3], frameQ[2], frameQ[1], frameQ[0]};
    expErr    = (n > (1 << AW));
    expDone   = !expErr;
    expWrites = expErr ? 0 : n;
    t = 0;
    while (!done && !err && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!done && !err) checkOutput({name, "_finish_timeout"}, 0, 1);
    @(negedge clk);
    checkOutput({name, "_done"}, done, expDone);
    checkOutput({name, "_err"}, err, expErr);
    checkOutput({name, "_busy"}, busy, 0);
    checkOutput({name, "_in_ready"}, in_ready, 0);
    if (expDone) loadedModel = 1'b1;
    checkOutput({name, "_core_rst_n"}, core_rst_n, loadedModel);
    checkOutput({name, "_write_count"}, gotAddr.size(), expWrites);
    for (int i = 0; i < expWrites && i < gotAddr.size(); i++) begin
      checkOutput({name, "_addr"}, gotAddr[i], i);
      checkOutput({name, "_data"}, gotData[i],
                  {frameQ[4*i+7], frameQ[4*i+6], frameQ[4*i+5], frameQ[4*i+4]});
    end
    if (expWrites > 0) checkOutput({name, "_done_latency"}, doneCycle - lastWeCycle, 1);
  endtask

  initial begin
    // Reset and idle acceptance
    doReset();
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) begin
      @(negedge clk);
      checkOutput("idle_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;

    // Two-word frame, back-to-back
    frameQ = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    applyStimulus(0, -1);
    checkSession("two_words");

    // Empty program
    buildFrame(0, 0);
    applyStimulus(0, -1);
    checkSession("empty");

    // Full capacity
    buildFrame(16, 16);
    applyStimulus(1, -1);
    checkSession("full");

    // Oversize right after reset keeps the core held
    doReset();
    buildFrame(17, 0);
    applyStimulus(0, -1);
    checkSession("oversize");

    // Two-word frame with gaps and an ignored mid-load start
    frameQ = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    applyStimulus(5, 6);
    checkSession("gaps_midstart");

    // Random frames
    for (int s = 0; s < 6; s++) begin
      int n;
      n = $urandom_range(18, 0);
      buildFrame(n, (n > 16) ? 0 : n);
      applyStimulus($urandom_range(5, 0), -1);
      checkSession("random");
    end

    // Reset in the middle of word 1
    frameQ = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00};
    applyStimulus(0, -1);
    repeat (2) @(negedge clk);
    checkOutput("midreset_writes", gotAddr.size(), 1);
    doReset();
    checkOutput("midreset_no_word1", gotAddr.size(), 1);
    frameQ = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    applyStimulus(2, -1);
    checkSession("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
